multi_delay: RTL and testbench
==============================

MULTI_DELAY -- requirements
Module: multi_delay

Interface
REQ-001 Parameter NCH, default 4, number of independent delay channels (1..16).
REQ-002 Parameter CW, default 8, width of per-channel delay and pulse-width values and internal counters.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset; low clears all state immediately, release is synchronous to clk.
REQ-005 start  input  NCH  per-channel trigger, sampled at posedge clk.
REQ-006 cancel  input  NCH  per-channel abort, sampled at posedge clk.
REQ-007 dly  input  NCH*CW  per-channel delay in cycles; channel i at bits [i*CW +: CW].
REQ-008 pw  input  NCH*CW  per-channel pulse width in cycles; same packing as dly.
REQ-009 mode  input  2*NCH  per-channel mode: 0 one-shot, 1 restartable, 2 periodic, 3 reserved (behaves as 0).
REQ-010 pulse  output  NCH  registered per-channel delayed pulse.
REQ-011 busy  output  NCH  registered; high while the channel is not IDLE.

Function
REQ-012 Each channel SHALL run a 3-state FSM: IDLE, DELAY, PULSE; channels are fully independent.
REQ-013 IDLE: start=1 at edge E -> DELAY, cnt=1; dly, pw and mode latched at E (a value of 0 is latched as 1).
REQ-014 DELAY: cnt increments each edge; at the edge where cnt equals latched dly -> PULSE, pulse=1, cnt=1.
REQ-015 pulse SHALL rise at edge E+dly and stay high exactly pw cycles, falling at edge E+dly+pw.
REQ-016 End of PULSE: modes 0/1/3 -> IDLE; mode 2 -> DELAY with cnt=1, giving a period of dly+pw cycles.
REQ-017 Mode 0/3 and mode 2: start while busy SHALL be ignored.
REQ-018 Mode 1: start while busy SHALL force pulse=0, DELAY, cnt=1, and re-latch dly/pw/mode at that edge.
REQ-019 cancel=1 in any state SHALL return to IDLE with pulse=0 at that edge; cancel has priority over a simultaneous start.
REQ-020 dly, pw and mode changes while busy SHALL have no effect except on restart in mode 1.
REQ-021 busy SHALL rise at edge E and fall at the edge the channel enters IDLE.
REQ-022 Counters SHALL never wrap: the maximum dly/pw of 2^CW-1 SHALL be honoured exactly.

Reset
REQ-023 reset low SHALL force every channel to IDLE, cnt=0, latched values=0, pulse=0, busy=0, independent of clk.
REQ-024 reset asserted mid-DELAY or mid-PULSE SHALL drop pulse and busy immediately and raise no pulse after release.
REQ-025 The first start sampled after reset release SHALL behave exactly as in REQ-013.

Structure
REQ-026 The mode encodings and the FSM state encoding SHALL be constants in a shared package, multi_delay_pkg.
REQ-027 Per-channel logic SHALL live in one sub-module, delay_channel, instantiated NCH times by a generate loop; multi_delay contains only packing and instantiation.

Verification
REQ-028 NCH=4, CW=8, ch0 mode 0, dly=7, pw=1, start at edge 10 -> busy rises at 10, pulse high during edges 17..18 only, busy falls at 18.
REQ-029 ch1 mode 1, dly=5, pw=2, start at 0 and again at 3 -> single pulse rising at 8 and falling at 10; no pulse at 5.
REQ-030 ch2 mode 2, dly=3, pw=2, start at 0, cancel at 14 -> pulse rises at 3, 8 and 13; pulse and busy are low from edge 14.
REQ-031 ch3 mode 0, dly=0, pw=0, start at 0 -> treated as 1/1: pulse high from edge 1 to edge 2; start and cancel together at 20 -> stays IDLE.
REQ-032 ch0 dly=255, pw=255, start at 0, reset low at edge 300 -> pulse rises at 255 and drops asynchronously at reset; all outputs 0 through release; start after release produces a pulse at start+255.
REQ-033 All four channels started on the same edge with distinct dly values -> each pulse is timed per REQ-015 with no cross-channel interaction.

Source files
------------

// File: rtl/multi_delay_pkg.sv
// multi_delay_pkg
//   Shared constants for the multi-channel delay/pulse generator:
//   per-channel FSM state encoding and the mode encodings.
package multi_delay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_RESTART  = 2'd1;
  localparam logic [1:0] MODE_PERIODIC = 2'd2;
  localparam logic [1:0] MODE_RSVD     = 2'd3;  // handled like one-shot

endpackage

// File: rtl/delay_channel.sv
// delay_channel
//   One independent delay/pulse channel. A start in IDLE latches dly/pw/mode
//   (zero values become 1), waits dly cycles, then drives pulse high for pw
//   cycles. Periodic mode loops back to DELAY; restartable mode re-arms on a
//   start while busy; cancel aborts from any state and beats start.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   start,cancel : trigger / abort, sampled at posedge clk
//   dly, pw      : delay and pulse width in cycles (CW bits)
//   mode         : 0 one-shot, 1 restartable, 2 periodic, 3 as one-shot
//   pulse, busy  : registered outputs
//   state        : current FSM state (debug visibility)
module delay_channel
  import multi_delay_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          cancel,
  input  logic [CW-1:0] dly,
  input  logic [CW-1:0] pw,
  input  logic [1:0]    mode,
  output logic          pulse,
  output logic          busy,
  output logic [1:0]    state
);

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_q, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] dly_l, dly_nxt;
  logic [CW-1:0] pw_l, pw_nxt;
  logic [1:0]    mode_l, mode_nxt;
  logic          pulse_nxt;
  logic          busy_nxt;
  logic          restart;

  assign state = state_q;

  // A start is accepted from IDLE, or at any time when the latched mode is
  // restartable.
  assign restart = start && ((state_q == ST_IDLE) || (mode_l == MODE_RESTART));

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt;
    dly_nxt   = dly_l;
    pw_nxt    = pw_l;
    mode_nxt  = mode_l;
    pulse_nxt = pulse;
    if (cancel) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      pulse_nxt = 1'b0;
    end else if (restart) begin
      state_nxt = ST_DELAY;
      cnt_nxt   = ONE;
      dly_nxt   = (dly == '0) ? ONE : dly;
      pw_nxt    = (pw == '0) ? ONE : pw;
      mode_nxt  = mode;
      pulse_nxt = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_DELAY: begin
          // cnt counts 1..dly, so it never exceeds the latched value and
          // the full 2^CW-1 range is usable without wrapping.
          if (cnt == dly_l) begin
            state_nxt = ST_PULSE;
            cnt_nxt   = ONE;
            pulse_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
        ST_PULSE: begin
          if (cnt == pw_l) begin
            pulse_nxt = 1'b0;
            if (mode_l == MODE_PERIODIC) begin
              state_nxt = ST_DELAY;
              cnt_nxt   = ONE;
            end else begin
              state_nxt = ST_IDLE;
              cnt_nxt   = '0;
            end
          end else begin
            cnt_nxt = cnt + ONE;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          pulse_nxt = 1'b0;
        end
      endcase
    end
    busy_nxt = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt     <= '0;
      dly_l   <= '0;
      pw_l    <= '0;
      mode_l  <= '0;
      pulse   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt     <= cnt_nxt;
      dly_l   <= dly_nxt;
      pw_l    <= pw_nxt;
      mode_l  <= mode_nxt;
      pulse   <= pulse_nxt;
      busy    <= busy_nxt;
    end
  end

endmodule

// File: rtl/multi_delay.sv
// multi_delay
//   NCH independent delay/pulse channels sharing one clock and reset.
//   Only unpacks the per-channel fields and instantiates delay_channel.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   start      : [NCH]      per-channel trigger
//   cancel     : [NCH]      per-channel abort
//   dly, pw    : [NCH*CW]   channel i at [i*CW +: CW]
//   mode       : [2*NCH]    channel i at [2*i +: 2]
//   pulse,busy : [NCH]      registered per-channel outputs
//   state      : [2*NCH]    per-channel FSM state, channel i at [2*i +: 2]
module multi_delay
  import multi_delay_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    start,
  input  logic [NCH-1:0]    cancel,
  input  logic [NCH*CW-1:0] dly,
  input  logic [NCH*CW-1:0] pw,
  input  logic [2*NCH-1:0]  mode,
  output logic [NCH-1:0]    pulse,
  output logic [NCH-1:0]    busy,
  output logic [2*NCH-1:0]  state
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    delay_channel #(.CW(CW)) u_ch (
      .clk    (clk),
      .reset  (reset),
      .start  (start[i]),
      .cancel (cancel[i]),
      .dly    (dly[i*CW +: CW]),
      .pw     (pw[i*CW +: CW]),
      .mode   (mode[2*i +: 2]),
      .pulse  (pulse[i]),
      .busy   (busy[i]),
      .state  (state[2*i +: 2])
    );
  end

endmodule

// File: tb/tb_multi_delay.sv
// tb_multi_delay
//   Directed scenarios plus randomized traffic against a timeline model:
//   each active channel remembers its start edge t0 and latched d/p/mode,
//   and outputs are derived from k = edge - t0 with plain arithmetic.
module tb_multi_delay;

  localparam int NCH = 4;
  localparam int CW  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NCH-1:0]    start, cancel;
  logic [NCH*CW-1:0] dly, pw;
  logic [2*NCH-1:0]  mode;
  logic [NCH-1:0]    pulse, busy;
  logic [2*NCH-1:0]  state;

  multi_delay #(.NCH(NCH), .CW(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .cancel (cancel),
    .dly    (dly),
    .pw     (pw),
    .mode   (mode),
    .pulse  (pulse),
    .busy   (busy),
    .state  (state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  int n        = 0;  // posedge index
  logic [2*NCH-1:0] exp_q[$];  // {busy, pulse} expected after each edge

  bit act[NCH];
  int t0[NCH], d[NCH], p[NCH], m[NCH];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", tag, n, obs, exp);
    end
  endtask

  // Reference: apply this edge's cancel/start, then derive outputs from
  // elapsed cycles since the accepted start.
  task automatic model_step();
    logic [NCH-1:0] ep, eb;
    ep = '0;
    eb = '0;
    for (int i = 0; i < NCH; i++) begin
      logic [CW-1:0] dv, pv;
      int k;
      if (cancel[i]) begin
        act[i] = 1'b0;
      end else if (start[i] && (!act[i] || m[i] == 1)) begin
        dv = dly[i*CW +: CW];
        pv = pw[i*CW +: CW];
        act[i] = 1'b1;
        t0[i]  = n;
        d[i]   = (dv == 0) ? 1 : int'(dv);
        p[i]   = (pv == 0) ? 1 : int'(pv);
        m[i]   = int'(mode[2*i +: 2]);
      end
      if (act[i]) begin
        k = n - t0[i];
        if (m[i] == 2) begin
          eb[i] = 1'b1;
          ep[i] = ((k % (d[i] + p[i])) >= d[i]);
        end else if (k >= d[i] + p[i]) begin
          act[i] = 1'b0;
        end else begin
          eb[i] = 1'b1;
          ep[i] = (k >= d[i]);
        end
      end
    end
    exp_q.push_back({eb, ep});
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_cycle();
    logic [2*NCH-1:0] e;
    @(posedge clk);
    n++;
    model_step();
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("pulse", {28'd0, pulse}, {28'd0, e[NCH-1:0]});
      check_eq("busy", {28'd0, busy}, {28'd0, e[2*NCH-1:NCH]});
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) run_cycle();
  endtask

  task automatic fire(input logic [NCH-1:0] s, input logic [NCH-1:0] c);
    start  = s;
    cancel = c;
    run_cycle();
    start  = '0;
    cancel = '0;
  endtask

  task automatic set_ch(input int i, input int dv, input int pv, input int mv);
    dly[i*CW +: CW] = CW'(dv);
    pw[i*CW +: CW]  = CW'(pv);
    mode[2*i +: 2]  = 2'(mv);
  endtask

  // Reset asserted between edges: outputs must drop without a clock edge.
  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check_eq("rst_async_pulse", {28'd0, pulse}, 32'd0);
    check_eq("rst_async_busy", {28'd0, busy}, 32'd0);
    for (int i = 0; i < NCH; i++) act[i] = 1'b0;
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_hold_pulse", {28'd0, pulse}, 32'd0);
      check_eq("rst_hold_busy", {28'd0, busy}, 32'd0);
      check_eq("rst_hold_state", {24'd0, state}, 32'd0);
    end
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset  = 1'b0;
    start  = '0;
    cancel = '0;
    dly    = '0;
    pw     = '0;
    mode   = '0;
    for (int i = 0; i < NCH; i++) act[i] = 1'b0;
    #1;
    check_eq("por_pulse", {28'd0, pulse}, 32'd0);
    check_eq("por_busy", {28'd0, busy}, 32'd0);
    check_eq("por_state", {24'd0, state}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // ch0 one-shot dly=7 pw=1, started after some idle cycles
    set_ch(0, 7, 1, 0);
    idle(9);
    fire(4'b0001, 4'b0000);
    idle(12);

    // ch1 restartable: second start at +3 re-arms, single pulse
    set_ch(1, 5, 2, 1);
    fire(4'b0010, 4'b0000);
    idle(2);
    fire(4'b0010, 4'b0000);
    idle(12);

    // ch2 periodic, cancelled at +14
    set_ch(2, 3, 2, 2);
    fire(4'b0100, 4'b0000);
    idle(13);
    fire(4'b0000, 4'b0100);
    idle(5);

    // ch3 zero dly/pw treated as 1/1; start+cancel together stays idle
    set_ch(3, 0, 0, 0);
    fire(4'b1000, 4'b0000);
    idle(19);
    fire(4'b1000, 4'b1000);
    idle(3);

    // ch0 maximum delay/width, reset mid-pulse, then restart
    set_ch(0, 255, 255, 0);
    fire(4'b0001, 4'b0000);
    idle(299);
    do_reset();
    fire(4'b0001, 4'b0000);
    idle(260);

    // all channels together, distinct delays
    set_ch(0, 3, 2, 0);
    set_ch(1, 6, 1, 0);
    set_ch(2, 9, 4, 3);
    set_ch(3, 12, 3, 0);
    fire(4'b1111, 4'b0000);
    idle(25);

    // randomized traffic, including config changes while busy
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 63) == 0)
            set_ch(i, $urandom_range(200, 255), $urandom_range(0, 40), $urandom_range(0, 3));
          else
            set_ch(i, $urandom_range(0, 12), $urandom_range(0, 8), $urandom_range(0, 3));
        end
        start[i]  = ($urandom_range(0, 7) == 0);
        cancel[i] = ($urandom_range(0, 31) == 0);
      end
      run_cycle();
      if (cyc == 1500) begin
        start  = '0;
        cancel = '0;
        do_reset();
      end
    end
    start  = '0;
    cancel = '0;
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
